// File: rtl/fsm_seq_scheduler.sv
// fsm_seq_scheduler: round-robin arbiter that lends one shared A/B/C phase sequencer to
// N_REQ requesters, one job per grant. Each job kicks the sequencer out of park, inserts
// the requested number of short s0->s4 loops, and acknowledges on the return to park.
// Optional macro WATCHDOG_EN adds a TIMEOUT-cycle abort; without it error_o is tied low.
module fsm_seq_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned REP_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ-1:0]       tail_i,
  input  logic [N_REQ*REP_W-1:0] reps_i,
  input  logic                   d_i,
  input  logic                   e_i,
  input  logic                   f_i,
  output logic                   a_o,
  output logic                   b_o,
  output logic                   c_o,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic                   error_o
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam logic [IdxW:0] NReqW = (IdxW + 1)'(N_REQ);

  typedef enum logic [2:0] {StParkWait, StIdle, StKick, StRun, StDone} state_e;

  state_e           state_q;
  logic [IdxW-1:0]  rr_q;
  logic [IdxW-1:0]  own_q;
  logic             tail_q;
  logic [REP_W-1:0] rep_cnt_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] done_q;
  logic             busy_q;

  // Sequencer sits in s0 when none of its phase outputs is active.
  logic in_s0;
  assign in_s0 = ~d_i & ~e_i & ~f_i;

  logic [N_REQ-1:0] req_rot;
  logic [IdxW-1:0]  pick_off;
  logic [IdxW:0]    pick_sum;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_vld;
  logic             pick_tail;
  logic [REP_W-1:0] pick_reps;
  logic [IdxW:0]    rr_sum;
  logic [IdxW-1:0]  rr_inc;

  // Round-robin pick: rotate requests so the pointer lands at bit 0, take the lowest set bit.
  always_comb begin
    req_rot  = N_REQ'({req_i, req_i} >> rr_q);
    pick_off = '0;
    pick_vld = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        pick_vld = 1'b1;
        pick_off = IdxW'(j);
      end
    end
    pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
    pick_idx = (pick_sum >= NReqW) ? IdxW'(pick_sum - NReqW) : pick_sum[IdxW-1:0];
    pick_tail = 1'b0;
    pick_reps = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_idx == IdxW'(k)) begin
        pick_tail = tail_i[k];
        pick_reps = reps_i[k*REP_W +: REP_W];
      end
    end
    rr_sum = {1'b0, own_q} + (IdxW + 1)'(1);
    rr_inc = (rr_sum >= NReqW) ? '0 : rr_sum[IdxW-1:0];
  end

  // Sequencer drive: decoded from registered state and live phase inputs only.
  always_comb begin
    b_o = (state_q == StKick);
    c_o = (state_q == StKick) & tail_q;
    a_o = (state_q == StRun) & in_s0 & (rep_cnt_q != '0);
  end

`ifdef WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  logic [WdW-1:0] wd_q;
  logic           error_q;
  logic           wd_hit;
  assign wd_hit  = (wd_q == WdW'(TIMEOUT - 1));
  assign error_o = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign error_o = 1'b0;
`endif

  // Job sequencing FSM with registered grant/done/busy outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StParkWait;
      rr_q      <= '0;
      own_q     <= '0;
      tail_q    <= 1'b0;
      rep_cnt_q <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b1;
`ifdef WATCHDOG_EN
      wd_q      <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      unique case (state_q)
        StParkWait: begin
          if (f_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StIdle: begin
          if (pick_vld) begin
            own_q     <= pick_idx;
            grant_q   <= N_REQ'(1) << pick_idx;
            tail_q    <= pick_tail;
            rep_cnt_q <= pick_reps;
            busy_q    <= 1'b1;
            state_q   <= StKick;
          end
        end
        StKick: state_q <= StRun;
        StRun: begin
          if (a_o) rep_cnt_q <= rep_cnt_q - REP_W'(1);
          if (f_i) begin
            state_q <= StDone;
            done_q  <= grant_q;
          end
        end
        StDone: begin
          grant_q <= '0;
          rr_q    <= rr_inc;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StParkWait;
      endcase
`ifdef WATCHDOG_EN
      error_q <= 1'b0;
      if (state_q == StKick) begin
        wd_q <= '0;
      end else if (state_q == StRun || state_q == StParkWait) begin
        wd_q <= wd_q + WdW'(1);
      end
      // A normal return to park wins over a timeout in the same cycle.
      if (wd_hit && !f_i && (state_q == StRun || state_q == StParkWait)) begin
        error_q <= 1'b1;
        grant_q <= '0;
        done_q  <= '0;
        busy_q  <= 1'b1;
        wd_q    <= '0;
        state_q <= StParkWait;
      end
`endif
    end
  end

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;

endmodule
